arch_map_table: RTL and testbench

Architectural (committed) register map table sitting at retire, directly upstream of the speculative free list. Each cycle it accepts up to four retiring instructions, records each instruction's new physical destination as the committed mapping of its logical register, and releases the previously committed physical register to the free list one cycle later. On recovery it exposes the full committed map so the speculative rename table can be restored.

---
 rtl/arch_map_table_pkg.sv | 21 ++
 rtl/arch_map_table_if.sv | 44 ++++
 rtl/arch_map_table_dep_check.sv | 38 +++
 rtl/arch_map_table.sv | 94 +++++++++
 tb/tb_arch_map_table.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/arch_map_table_pkg.sv
// -----------------------------------------------------------------------------
// arch_map_table_pkg
// Shared definitions for the architectural (committed) register map table:
// table geometry, tag widths, retire width and the per-slot commit record.
// -----------------------------------------------------------------------------
package arch_map_table_pkg;

    localparam int LOG_REGS  = 32;
    localparam int PHYS_REGS = 96;
    localparam int LOG_W     = $clog2(LOG_REGS);
    localparam int PHYS_W    = $clog2(PHYS_REGS);
    localparam int RET_W     = 4;
    localparam int SLOT_W    = $clog2(RET_W);

    typedef struct packed {
        logic              valid;
        logic [LOG_W-1:0]  logDest;
        logic [PHYS_W-1:0] phyDest;
    } commitSlot_t;

endpackage

// File: rtl/arch_map_table_if.sv
// -----------------------------------------------------------------------------
// arch_map_table_if
// Retire-side and release-side signals of the architectural map table.
//   master : retire stage / testbench  (drives retire slots and recoverFlag_i)
//   slave  : arch_map_table            (drives free-list release and archMap_o)
// Ports:
//   retValidN_i, retLogDestN_i, retPhyDestN_i  retiring slot N (N = 0..3)
//   recoverFlag_i                              pipeline flush
//   freeValidN_o, freeRegN_o                   registered release to free list
//   archMap_o                                  committed map, entry i at
//                                              [i*PHYS_W +: PHYS_W]
// -----------------------------------------------------------------------------
interface arch_map_table_if;
    import arch_map_table_pkg::*;

    logic                       retValid0_i, retValid1_i, retValid2_i, retValid3_i;
    logic [LOG_W-1:0]           retLogDest0_i, retLogDest1_i, retLogDest2_i, retLogDest3_i;
    logic [PHYS_W-1:0]          retPhyDest0_i, retPhyDest1_i, retPhyDest2_i, retPhyDest3_i;
    logic                       recoverFlag_i;
    logic                       freeValid0_o, freeValid1_o, freeValid2_o, freeValid3_o;
    logic [PHYS_W-1:0]          freeReg0_o, freeReg1_o, freeReg2_o, freeReg3_o;
    logic [LOG_REGS*PHYS_W-1:0] archMap_o;

    modport master (
        output retValid0_i, retValid1_i, retValid2_i, retValid3_i,
        output retLogDest0_i, retLogDest1_i, retLogDest2_i, retLogDest3_i,
        output retPhyDest0_i, retPhyDest1_i, retPhyDest2_i, retPhyDest3_i,
        output recoverFlag_i,
        input  freeValid0_o, freeValid1_o, freeValid2_o, freeValid3_o,
        input  freeReg0_o, freeReg1_o, freeReg2_o, freeReg3_o,
        input  archMap_o
    );

    modport slave (
        input  retValid0_i, retValid1_i, retValid2_i, retValid3_i,
        input  retLogDest0_i, retLogDest1_i, retLogDest2_i, retLogDest3_i,
        input  retPhyDest0_i, retPhyDest1_i, retPhyDest2_i, retPhyDest3_i,
        input  recoverFlag_i,
        output freeValid0_o, freeValid1_o, freeValid2_o, freeValid3_o,
        output freeReg0_o, freeReg1_o, freeReg2_o, freeReg3_o,
        output archMap_o
    );

endinterface

// File: rtl/arch_map_table_dep_check.sv
// -----------------------------------------------------------------------------
// amt_dep_check
// Intra-group same-destination priority compare for the four retire slots.
// Ports:
//   slots      in   four commit records (valid, logDest, phyDest)
//   bypassHit  out  slot N has an older valid slot with the same logDest
//   bypassIdx  out  highest such older slot; its phyDest is N's old mapping
//   writeKill  out  a younger valid slot targets the same logDest, so slot N
//                   must not write the map
// -----------------------------------------------------------------------------
module amt_dep_check
    import arch_map_table_pkg::*;
(
    input  commitSlot_t       slots     [RET_W],
    output logic [RET_W-1:0]  bypassHit,
    output logic [SLOT_W-1:0] bypassIdx [RET_W],
    output logic [RET_W-1:0]  writeKill
);

    always_comb begin
        bypassHit = '0;
        writeKill = '0;
        for (int n = 0; n < RET_W; n++) begin
            bypassIdx[n] = '0;
            // Ascending scan: the last match is the youngest older producer.
            for (int m = 0; m < RET_W; m++) begin
                if (m < n && slots[m].valid && slots[m].logDest == slots[n].logDest) begin
                    bypassHit[n] = 1'b1;
                    bypassIdx[n] = SLOT_W'(m);
                end
                if (m > n && slots[m].valid && slots[m].logDest == slots[n].logDest) begin
                    writeKill[n] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/arch_map_table.sv
// -----------------------------------------------------------------------------
// arch_map_table
// Committed register map at retire. Each cycle up to four retiring slots record
// their new physical destination as the committed mapping of their logical
// register; the previously committed tag of each valid slot is released to the
// free list one cycle later, slot positions preserved. archMap_o exposes the
// full committed map for rename-table recovery.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  synchronous, active-high; map -> identity, releases cleared
//   bus    slave modport of arch_map_table_if (retire in, release/map out)
// -----------------------------------------------------------------------------
module arch_map_table
    import arch_map_table_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    arch_map_table_if.slave  bus
);

    commitSlot_t       slots_p0   [RET_W];
    logic [RET_W-1:0]  bypassHit_p0;
    logic [SLOT_W-1:0] bypassIdx_p0 [RET_W];
    logic [RET_W-1:0]  writeKill_p0;
    logic [PHYS_W-1:0] oldTag_p0  [RET_W];

    logic [PHYS_W-1:0] mapTbl     [LOG_REGS];
    logic [RET_W-1:0]  vld_p1;
    logic [PHYS_W-1:0] freeReg_p1 [RET_W];

    // Commits in a flush cycle are applied normally (retire precedes flush),
    // so the flag needs no action here; the restored map is simply archMap_o.
    logic unusedRecover;
    assign unusedRecover = bus.recoverFlag_i;

    assign slots_p0[0] = '{bus.retValid0_i, bus.retLogDest0_i, bus.retPhyDest0_i};
    assign slots_p0[1] = '{bus.retValid1_i, bus.retLogDest1_i, bus.retPhyDest1_i};
    assign slots_p0[2] = '{bus.retValid2_i, bus.retLogDest2_i, bus.retPhyDest2_i};
    assign slots_p0[3] = '{bus.retValid3_i, bus.retLogDest3_i, bus.retPhyDest3_i};

    amt_dep_check u_depCheck (
        .slots     (slots_p0),
        .bypassHit (bypassHit_p0),
        .bypassIdx (bypassIdx_p0),
        .writeKill (writeKill_p0)
    );

    // Old mapping: an older slot in the same group overrides the stored map.
    always_comb begin
        for (int n = 0; n < RET_W; n++) begin
            oldTag_p0[n] = bypassHit_p0[n] ? slots_p0[bypassIdx_p0[n]].phyDest
                                           : mapTbl[slots_p0[n].logDest];
        end
    end

    // ---- stage p0 -> p1: map write and release registers ----
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LOG_REGS; i++) begin
                mapTbl[i] <= PHYS_W'(i);
            end
            vld_p1 <= '0;
            for (int n = 0; n < RET_W; n++) begin
                freeReg_p1[n] <= '0;
            end
        end else begin
            for (int n = 0; n < RET_W; n++) begin
                // Kill guarantees at most one writer per logical index.
                if (slots_p0[n].valid && !writeKill_p0[n]) begin
                    mapTbl[slots_p0[n].logDest] <= slots_p0[n].phyDest;
                end
                vld_p1[n]     <= slots_p0[n].valid;
                freeReg_p1[n] <= slots_p0[n].valid ? oldTag_p0[n] : '0;
            end
        end
    end

    always_comb begin
        bus.archMap_o = '0;
        for (int i = 0; i < LOG_REGS; i++) begin
            bus.archMap_o[i*PHYS_W +: PHYS_W] = mapTbl[i];
        end
    end

    assign bus.freeValid0_o = vld_p1[0];
    assign bus.freeValid1_o = vld_p1[1];
    assign bus.freeValid2_o = vld_p1[2];
    assign bus.freeValid3_o = vld_p1[3];
    assign bus.freeReg0_o   = freeReg_p1[0];
    assign bus.freeReg1_o   = freeReg_p1[1];
    assign bus.freeReg2_o   = freeReg_p1[2];
    assign bus.freeReg3_o   = freeReg_p1[3];

endmodule

// File: tb/tb_arch_map_table.sv
module tb_arch_map_table;
    import arch_map_table_pkg::*;

    logic clk;
    logic reset;
    int   passCount;
    int   totalCount;

    arch_map_table_if bus ();

    arch_map_table dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    function automatic int mapAt(input int idx);
        logic [LOG_REGS*PHYS_W-1:0] flat;
        flat = bus.archMap_o;
        return int'(flat[idx*PHYS_W +: PHYS_W]);
    endfunction

    function automatic int freeVec();
        return int'({bus.freeValid3_o, bus.freeValid2_o, bus.freeValid1_o, bus.freeValid0_o});
    endfunction

    task automatic clearSlots();
        bus.retValid0_i = 0; bus.retLogDest0_i = '0; bus.retPhyDest0_i = '0;
        bus.retValid1_i = 0; bus.retLogDest1_i = '0; bus.retPhyDest1_i = '0;
        bus.retValid2_i = 0; bus.retLogDest2_i = '0; bus.retPhyDest2_i = '0;
        bus.retValid3_i = 0; bus.retLogDest3_i = '0; bus.retPhyDest3_i = '0;
        bus.recoverFlag_i = 0;
    endtask

    task automatic setSlot(input int n, input int ld, input int pd);
        case (n)
            0: begin bus.retValid0_i = 1; bus.retLogDest0_i = LOG_W'(ld); bus.retPhyDest0_i = PHYS_W'(pd); end
            1: begin bus.retValid1_i = 1; bus.retLogDest1_i = LOG_W'(ld); bus.retPhyDest1_i = PHYS_W'(pd); end
            2: begin bus.retValid2_i = 1; bus.retLogDest2_i = LOG_W'(ld); bus.retPhyDest2_i = PHYS_W'(pd); end
            default: begin bus.retValid3_i = 1; bus.retLogDest3_i = LOG_W'(ld); bus.retPhyDest3_i = PHYS_W'(pd); end
        endcase
    endtask

    // One rising edge, then settle to the falling edge for sampling.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        passCount  = 0;
        totalCount = 0;
        reset = 1;
        clearSlots();
        step();
        step();
        reset = 0;

        // Reset state
        check("rst_map5", mapAt(5), 5);
        check("rst_map0", mapAt(0), 0);
        check("rst_map31", mapAt(31), 31);
        check("rst_freeValid", freeVec(), 0);
        check("rst_freeReg0", int'(bus.freeReg0_o), 0);

        // Single retire r3->p40
        setSlot(0, 3, 40);
        step();
        clearSlots();
        check("single_freeValid", freeVec(), 4'b0001);
        check("single_freeReg0", int'(bus.freeReg0_o), 3);
        check("single_map3", mapAt(3), 40);

        // Three slots to r7
        setSlot(0, 7, 50); setSlot(1, 7, 51); setSlot(2, 7, 52);
        step();
        clearSlots();
        check("dup_freeValid", freeVec(), 4'b0111);
        check("dup_freeReg0", int'(bus.freeReg0_o), 7);
        check("dup_freeReg1", int'(bus.freeReg1_o), 50);
        check("dup_freeReg2", int'(bus.freeReg2_o), 51);
        check("dup_map7", mapAt(7), 52);

        // Sparse slots 1 and 3
        setSlot(1, 1, 60); setSlot(3, 2, 61);
        step();
        clearSlots();
        check("sparse_freeValid", freeVec(), 4'b1010);
        check("sparse_freeReg1", int'(bus.freeReg1_o), 1);
        check("sparse_freeReg3", int'(bus.freeReg3_o), 2);
        check("sparse_freeReg0", int'(bus.freeReg0_o), 0);
        check("sparse_map1", mapAt(1), 60);
        check("sparse_map2", mapAt(2), 61);

        // Back-to-back r4 -> p70 then p71
        setSlot(0, 4, 70);
        step();
        clearSlots();
        check("b2b_t1_freeReg0", int'(bus.freeReg0_o), 4);
        setSlot(0, 4, 71);
        step();
        clearSlots();
        check("b2b_t2_freeReg0", int'(bus.freeReg0_o), 70);
        check("b2b_map4", mapAt(4), 71);

        // Non-adjacent duplicate plus lookup of earlier committed map[3]=40
        setSlot(0, 5, 72); setSlot(2, 5, 73); setSlot(3, 3, 74);
        step();
        clearSlots();
        check("gap_freeValid", freeVec(), 4'b1101);
        check("gap_freeReg0", int'(bus.freeReg0_o), 5);
        check("gap_freeReg2", int'(bus.freeReg2_o), 72);
        check("gap_freeReg3", int'(bus.freeReg3_o), 40);
        check("gap_map5", mapAt(5), 73);
        check("gap_map3", mapAt(3), 74);

        // All four slots to r10
        setSlot(0, 10, 84); setSlot(1, 10, 85); setSlot(2, 10, 86); setSlot(3, 10, 87);
        step();
        clearSlots();
        check("all4_freeReg0", int'(bus.freeReg0_o), 10);
        check("all4_freeReg1", int'(bus.freeReg1_o), 84);
        check("all4_freeReg3", int'(bus.freeReg3_o), 86);
        check("all4_map10", mapAt(10), 87);

        // Recovery with a commit in the same cycle
        setSlot(0, 9, 80);
        bus.recoverFlag_i = 1;
        step();
        clearSlots();
        check("recover_freeValid", freeVec(), 4'b0001);
        check("recover_freeReg0", int'(bus.freeReg0_o), 9);
        check("recover_map9", mapAt(9), 80);

        // Idle cycle drops releases
        step();
        check("idle_freeValid", freeVec(), 0);
        check("idle_freeReg0", int'(bus.freeReg0_o), 0);

        // Reset asserted with a retire pending
        setSlot(0, 11, 88);
        reset = 1;
        step();
        reset = 0;
        clearSlots();
        check("midrst_freeValid", freeVec(), 0);
        check("midrst_map11", mapAt(11), 11);
        check("midrst_map3", mapAt(3), 3);
        check("midrst_map10", mapAt(10), 10);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
